credit_fifo: RTL and testbench
==============================

# credit_fifo

- Credit-based elastic buffer that sits directly downstream of a fixed-latency delay chain.
- Captures each valid word leaving the chain and presents it on a valid/ready output port.
- Returns credits upstream so the launching logic never sends more words into the chain than the buffer can hold. Backpressure therefore never has to stall the chain itself.

## Interface
Parameters:
- DW, 8: data width in bits.
- DEPTH, 8: buffer entries; power of two, ≥2.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock for all state.
- rst  in  1  synchronous active-high reset.
- launch  in  1  upstream puts one word into the delay chain this cycle; legal only while credit_ok=1.
- credit_ok  out  1  at least one credit is available; combinational from the credit counter.
- in_valid  in  1  delay-chain output word is valid this cycle.
- in_data  in  DW  delay-chain output data.
- out_valid  out  1  buffer non-empty.
- out_ready  in  1  consumer accepts the head word.
- out_data  out  DW  head word, first-word-fall-through.
- count  out  $clog2(DEPTH+1)  current occupancy.
- overflow  out  1  sticky protocol-error flag.
- underflow  out  1  sticky flag: a launch was issued with no credit.

## Operation
- Credit counter `credits` (width $clog2(DEPTH+1)):
  - Reset value is DEPTH.
  - Decrements by 1 on launch.
  - Increments by 1 on pop, where pop = out_valid & out_ready.
  - launch and pop in the same cycle: value unchanged.
  - credit_ok = (credits != 0).
- Launch with credits==0: counter holds at 0, underflow is set, and the launch consumes no credit.
- Push = in_valid. Data is written at wr_ptr, and wr_ptr increments modulo DEPTH.
- Pop advances rd_ptr modulo DEPTH.
- Pointers are $clog2(DEPTH) bits and wrap naturally; full and empty are resolved from count, not from the pointers.
- count rules:
  - Increments on push-only and decrements on pop-only.
  - Unchanged on push+pop.
  - Push+pop at count==DEPTH is accepted: the read of the old head and the write of the new word occur in the same cycle.
  - Push+pop at count==0 is not a bypass. The word is written, out_valid rises next cycle, and that cycle's pop is ignored because out_valid=0.
- Push while count==DEPTH with no pop: the word is dropped, pointers and count hold, and overflow is set. This case is unreachable under correct credit use.
- Invariant: count + (words in flight in the chain) ≤ DEPTH, maintained by the credits.
- overflow and underflow are cleared only by rst.

## Timing
- Reset, checked on the first edge with rst=1:
  - credits=DEPTH, credit_ok=1.
  - count=0, out_valid=0.
  - Pointers are 0.
  - overflow=0, underflow=0.
  - out_data is don't-care while out_valid=0.
- Reset mid-operation discards all buffered words and restores full credit. Upstream must flush the delay chain in the same reset, so no stale in_valid appears after reset.
- Push-to-output latency is 1 cycle: a word written at edge N is visible on out_data/out_valid after edge N.
- Credit return latency is 1 cycle: a pop at edge N makes credit_ok=1 after edge N (if credits was 0).
- Round-trip latency is launch → chain latency → push → 1 → out_valid.
- Inputs are sampled only at the rising edge of clk. No combinational path exists from in_valid or in_data to credit_ok.
- A single combinational path exists from out_ready to nothing. Pop affects only next-state logic.

## Structure
- Package credit_fifo_pkg holds:
  - functions ptr_w(DEPTH) = $clog2(DEPTH) and cnt_w(DEPTH) = $clog2(DEPTH+1);
  - a parameter check function asserting DEPTH is a power of two and ≥2.
- Sub-module fifo_mem:
  - DW×DEPTH register array;
  - synchronous write port (we, waddr, wdata);
  - asynchronous read port (raddr → rdata).
- Top level contains the credit counter, pointers, count and error flags.

## Test plan
- Reset: hold rst 2 cycles → credits=8, credit_ok=1, count=0, out_valid=0, overflow=0, underflow=0.
- Fill through a 5-stage delay chain with out_ready=0:
  - launch 8 consecutive cycles → credit_ok=0 after the 8th launch.
  - Words 0x10..0x17 arrive 5 cycles later → count=8, out_valid=1, out_data=0x10.
- Drain with out_ready=1 from full → outputs 0x10..0x17 in order, one per cycle; credit_ok=1 one cycle after the first pop; count=0 after 8 pops.
- Simultaneous events at credits=0, count=8:
  - launch+pop in the same cycle → credits stays 0, count decrements, no overflow.
  - Pointer wrap is verified by 20 further words passing in order with out_ready toggling pseudo-randomly.
- Error injection:
  - Force in_valid with count=8, out_ready=0 → overflow=1 and stays set; count stays 8; head data unchanged.
  - launch at credits=0 → underflow=1, credits stays 0.
- Reset mid-operation: with count=5, assert rst 1 cycle → next cycle count=0, out_valid=0, credits=8, and overflow and underflow are cleared.

Source files
------------

// File: rtl/credit_fifo_pkg.sv
// Shared sizing helpers for the credit-based elastic buffer.
package credit_fifo_pkg;

    // Pointer width: indexes DEPTH entries and wraps naturally.
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Counter width: must represent 0..DEPTH inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Legal depth: power of two and at least 2.
    function automatic bit depth_ok(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/credit_fifo_mem.sv
// Register-array storage: synchronous write, asynchronous read.
module fifo_mem
    import credit_fifo_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [ptr_w(DEPTH)-1:0] waddr,
    input  logic [DW-1:0]           wdata,
    input  logic [ptr_w(DEPTH)-1:0] raddr,
    output logic [DW-1:0]           rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Write port; storage carries no reset because occupancy gates its use.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/credit_fifo.sv
// Elastic buffer behind a fixed-latency chain, with upstream credit return.
module credit_fifo
    import credit_fifo_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    launch,
    output logic                    credit_ok,
    input  logic                    in_valid,
    input  logic [DW-1:0]           in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DW-1:0]           out_data,
    output logic [cnt_w(DEPTH)-1:0] count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("credit_fifo: DEPTH must be a power of two and >= 2");
    end

    logic [CW-1:0] credits, credits_nxt;
    logic [CW-1:0] count_q, count_nxt;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          overflow_q, underflow_q;
    logic          pop, push, full, wr_en;
    logic          ovf_evt, unf_evt;

    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    assign push      = in_valid;
    assign full      = (count_q == FULL);
    // At full, a push is only accepted when the head leaves in the same cycle.
    assign wr_en     = push & (~full | pop);
    assign ovf_evt   = push & full & ~pop;
    // A launch paired with a pop trades the returned credit directly, so it
    // is only an error when no credit is available and none comes back.
    assign unf_evt   = launch & ~pop & (credits == '0);

    // Next credit value; held inside 0..DEPTH.
    always_comb begin
        credits_nxt = credits;
        if (launch && !pop) begin
            if (credits != '0) begin
                credits_nxt = credits - CW'(1);
            end
        end else if (pop && !launch) begin
            if (credits != FULL) begin
                credits_nxt = credits + CW'(1);
            end
        end
    end

    // Next occupancy: writes and reads cancel, dropped writes do not count.
    always_comb begin
        count_nxt = count_q;
        if (wr_en && !pop) begin
            count_nxt = count_q + CW'(1);
        end else if (pop && !wr_en) begin
            count_nxt = count_q - CW'(1);
        end
    end

    // State update: credits, pointers, occupancy and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            credits     <= FULL;
            count_q     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            credits <= credits_nxt;
            count_q <= count_nxt;
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (ovf_evt) begin
                overflow_q <= 1'b1;
            end
            if (unf_evt) begin
                underflow_q <= 1'b1;
            end
        end
    end

    fifo_mem #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (in_data),
        .raddr (rd_ptr),
        .rdata (out_data)
    );

    assign credit_ok = (credits != '0);
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_credit_fifo.sv
// Bench for credit_fifo: 5-stage chain model, scoreboard, and a vector table.
module tb_credit_fifo;

    localparam int LAT = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       launch = 1'b0;
    logic       credit_ok;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    int tests = 0;
    int fails = 0;

    logic       chain_v [LAT];
    logic [7:0] chain_d [LAT];
    logic [7:0] sb [$];
    int         m_count;
    int         m_cred;

    typedef struct {
        logic       launch;
        logic       in_valid;
        logic [7:0] in_data;
        logic       out_ready;
        logic [3:0] exp_count;
        logic       exp_cok;
        logic       exp_ov;
        logic [7:0] exp_head;
        logic       exp_ovf;
        logic       exp_unf;
    } vec_t;

    vec_t tbl [14];

    credit_fifo #(.DW(8), .DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .launch    (launch),
        .credit_ok (credit_ok),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic l, input logic iv, input logic [7:0] d,
                                input logic rdy, input logic [3:0] c, input logic cok,
                                input logic ov, input logic [7:0] h, input logic ovf,
                                input logic unf);
        vec_t v;
        v.launch = l; v.in_valid = iv; v.in_data = d; v.out_ready = rdy;
        v.exp_count = c; v.exp_cok = cok; v.exp_ov = ov; v.exp_head = h;
        v.exp_ovf = ovf; v.exp_unf = unf;
        return v;
    endfunction

    function automatic bit chain_empty();
        for (int i = 0; i < LAT; i++) begin
            if (chain_v[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic do_reset(input int n);
        rst = 1'b1; launch = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        m_count = 0;
        m_cred  = 8;
        sb.delete();
        for (int i = 0; i < LAT; i++) begin
            chain_v[i] = 1'b0;
            chain_d[i] = 8'h00;
        end
    endtask

    // One clock through the chain model; checks the head on pops and state after the edge.
    task automatic cycle(input logic l, input logic [7:0] ld, input logic rdy);
        logic pop_m, push_m;
        launch    = l;
        out_ready = rdy;
        in_valid  = chain_v[LAT-1];
        in_data   = chain_d[LAT-1];
        push_m    = chain_v[LAT-1];
        pop_m     = (m_count != 0) && rdy;
        chk("out_valid", out_valid, m_count != 0);
        if (pop_m) begin
            if (sb.size() == 0) begin
                chk("sb_underrun", 1, 0);
            end else begin
                chk("out_data", out_data, sb.pop_front());
            end
        end
        if (l) sb.push_back(ld);
        @(posedge clk);
        if (l && !pop_m) begin
            if (m_cred > 0) m_cred--;
        end else if (pop_m && !l) begin
            if (m_cred < 8) m_cred++;
        end
        if (push_m && !pop_m) begin
            if (m_count < 8) m_count++;
        end else if (pop_m && !push_m) begin
            m_count--;
        end
        for (int i = LAT - 1; i > 0; i--) begin
            chain_v[i] = chain_v[i-1];
            chain_d[i] = chain_d[i-1];
        end
        chain_v[0] = l;
        chain_d[0] = ld;
        #1;
        chk("count", count, m_count);
        chk("credit_ok", credit_ok, m_cred != 0);
    endtask

    initial begin
        int launched;
        int guard;

        for (int i = 0; i < 8; i++) begin
            tbl[i] = mk(1, 1, 8'hA0 + 8'(i), 0, 4'(i + 1), i < 7, 1, 8'hA0, 0, 0);
        end
        tbl[8]  = mk(0, 1, 8'hEE, 0, 8, 0, 1, 8'hA0, 1, 0);
        tbl[9]  = mk(0, 0, 8'h00, 0, 8, 0, 1, 8'hA0, 1, 0);
        tbl[10] = mk(1, 0, 8'h00, 0, 8, 0, 1, 8'hA0, 1, 1);
        tbl[11] = mk(0, 0, 8'h00, 1, 7, 1, 1, 8'hA1, 1, 1);
        tbl[12] = mk(0, 0, 8'h00, 1, 6, 1, 1, 8'hA2, 1, 1);
        tbl[13] = mk(0, 0, 8'h00, 1, 5, 1, 1, 8'hA3, 1, 1);

        // Reset held for two cycles.
        do_reset(2);
        chk("rst_credit_ok", credit_ok, 1);
        chk("rst_count", count, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_underflow", underflow, 0);

        // Fill through the chain with the consumer stalled.
        for (int i = 0; i < 8; i++) cycle(1, 8'h10 + 8'(i), 0);
        chk("fill_credit_ok", credit_ok, 0);
        for (int i = 0; i < 6; i++) cycle(0, 8'h00, 0);
        chk("fill_count", count, 8);
        chk("fill_out_valid", out_valid, 1);
        chk("fill_head", out_data, 8'h10);

        // Drain from full; credit_ok returns after the first pop.
        cycle(0, 8'h00, 1);
        chk("drain_credit_back", credit_ok, 1);
        for (int i = 0; i < 7; i++) cycle(0, 8'h00, 1);
        chk("drain_count", count, 0);
        chk("drain_out_valid", out_valid, 0);

        // Refill, then launch and pop together with no credits left.
        for (int i = 0; i < 8; i++) cycle(1, 8'h20 + 8'(i), 0);
        for (int i = 0; i < 6; i++) cycle(0, 8'h00, 0);
        chk("refill_count", count, 8);
        cycle(1, 8'h28, 1);
        chk("lp_count", count, 7);
        chk("lp_credit_ok", credit_ok, 0);
        chk("lp_overflow", overflow, 0);

        // Twenty more words through wrapping pointers with random backpressure.
        launched = 0;
        guard = 0;
        while (!(launched == 20 && sb.size() == 0 && chain_empty()) && guard < 2000) begin
            if (launched < 20 && m_cred > 0) begin
                cycle(1, 8'h29 + 8'(launched), 1'($urandom_range(0, 1)));
                launched++;
            end else begin
                cycle(0, 8'h00, 1'($urandom_range(0, 1)));
            end
            guard++;
        end
        chk("stream_timeout", guard < 2000, 1);
        chk("stream_overflow", overflow, 0);
        chk("stream_empty", count, 0);
        launch = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

        // Error injection driven straight onto the chain output.
        for (int i = 0; i < 14; i++) begin
            launch    = tbl[i].launch;
            in_valid  = tbl[i].in_valid;
            in_data   = tbl[i].in_data;
            out_ready = tbl[i].out_ready;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_count", i), count, tbl[i].exp_count);
            chk($sformatf("v%0d_credit_ok", i), credit_ok, tbl[i].exp_cok);
            chk($sformatf("v%0d_out_valid", i), out_valid, tbl[i].exp_ov);
            chk($sformatf("v%0d_overflow", i), overflow, tbl[i].exp_ovf);
            chk($sformatf("v%0d_underflow", i), underflow, tbl[i].exp_unf);
            if (tbl[i].exp_ov) chk($sformatf("v%0d_head", i), out_data, tbl[i].exp_head);
        end
        launch = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

        // Mid-operation reset with five words buffered.
        do_reset(1);
        chk("mrst_count", count, 0);
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_credit_ok", credit_ok, 1);
        chk("mrst_overflow", overflow, 0);
        chk("mrst_underflow", underflow, 0);

        // Full credit restored: exactly eight launches before credit_ok drops.
        for (int i = 0; i < 8; i++) begin
            launch = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("mrst_launch%0d", i), credit_ok, i < 7);
        end
        launch = 1'b0;
        chk("mrst_no_underflow", underflow, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
